// File: rtl/pc_gen.sv
// Fetch PC generator: owns the architectural fetch PC, drives the instruction SRAM
// address and the fetch-stage handshake. Optional ERET redirect when PCGEN_ERET_EN is defined.
module pc_gen #(
    parameter logic [31:0] RESET_VEC = 32'hbfc00000,
    parameter logic [31:0] EXC_VEC   = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        Is_branch_ID,
    input  logic        Branch_taken_ID,
    input  logic [31:0] Branch_target_ID,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] EPC,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] PC_next,
    output logic        PC_AdEL,
    output logic        IRWrite,
    output logic        DSI_ID
);

    // state | meaning
    // BOOT  | first cycle after reset: issue RESET_VEC, nothing valid to latch yet
    // RUN   | normal fetch, SRAM data for pc_q is valid every cycle
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_inc;
    logic [31:0] npc;
    logic [31:0] eret_target;
    logic        eret_hit;
    logic        ir_write;

`ifdef PCGEN_ERET_EN
    assign eret_hit    = eret_req;
    assign eret_target = EPC;
`else
    logic unused_eret;
    assign eret_hit    = 1'b0;
    assign eret_target = 32'd0;
    assign unused_eret = eret_req ^ (^EPC);
`endif

    // Redirects override stall: the vector word must be fetched regardless of hazards.
    always_comb begin
        pc_inc   = pc_q + 32'd4;
        npc      = pc_inc;
        ir_write = 1'b0;
        if (exc_req) begin
            npc = EXC_VEC;
        end else if (eret_hit) begin
            npc = eret_target;
        end else if (state_q == BOOT) begin
            npc = pc_inc;
        end else if (stall) begin
            npc = pc_q;
        end else if (Branch_taken_ID) begin
            npc      = Branch_target_ID;
            ir_write = 1'b1;
        end else begin
            ir_write = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= RESET_VEC - 32'd4;
            state_q <= BOOT;
        end else begin
            pc_q    <= npc;
            state_q <= RUN;
        end
    end

    // Misaligned PCs are issued aligned; the raw bits in pc_q raise AdEL at fetch.
    assign inst_sram_addr = {npc[31:2], 2'b00};
    assign PC_next        = pc_q;
    assign PC_AdEL        = (pc_q[1:0] != 2'b00);
    assign IRWrite        = ir_write;
    assign DSI_ID         = Is_branch_ID & (state_q == RUN) & ~exc_req & ~eret_hit;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: reset, sequential fetch, stall, branch,
// misaligned target, exception/ERET priority, wrap, boot redirect and async reset.
module tb_pc_gen;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        Is_branch_ID;
    logic        Branch_taken_ID;
    logic [31:0] Branch_target_ID;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] EPC;
    logic [31:0] inst_sram_addr;
    logic [31:0] PC_next;
    logic        PC_AdEL;
    logic        IRWrite;
    logic        DSI_ID;

    int total = 0;
    int bad   = 0;

    pc_gen dut (
        .clk              (clk),
        .resetn           (resetn),
        .stall            (stall),
        .Is_branch_ID     (Is_branch_ID),
        .Branch_taken_ID  (Branch_taken_ID),
        .Branch_target_ID (Branch_target_ID),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .EPC              (EPC),
        .inst_sram_addr   (inst_sram_addr),
        .PC_next          (PC_next),
        .PC_AdEL          (PC_AdEL),
        .IRWrite          (IRWrite),
        .DSI_ID           (DSI_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall            = 1'b0;
        Is_branch_ID     = 1'b0;
        Branch_taken_ID  = 1'b0;
        Branch_target_ID = 32'd0;
        exc_req          = 1'b0;
        eret_req         = 1'b0;
        EPC              = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #22;
        total++; if (PC_next !== 32'hbfbffffc) begin bad++; $display("FAIL rst_pc_next got=%h exp=bfbffffc", PC_next); end
        total++; if (inst_sram_addr !== 32'hbfc00000) begin bad++; $display("FAIL rst_addr got=%h exp=bfc00000", inst_sram_addr); end
        total++; if (IRWrite !== 1'b0) begin bad++; $display("FAIL rst_irwrite got=%b exp=0", IRWrite); end
        total++; if (DSI_ID !== 1'b0 || PC_AdEL !== 1'b0) begin bad++; $display("FAIL rst_dsi_adel got=%b%b exp=00", DSI_ID, PC_AdEL); end
    endtask

    task automatic test_boot_seq();
        step();
        resetn = 1'b1;
        #1;
        total++; if (IRWrite !== 1'b0 || inst_sram_addr !== 32'hbfc00000) begin bad++; $display("FAIL boot_cycle got=%b/%h exp=0/bfc00000", IRWrite, inst_sram_addr); end
        step();
        total++; if (IRWrite !== 1'b1 || PC_next !== 32'hbfc00000) begin bad++; $display("FAIL first_fetch got=%b/%h exp=1/bfc00000", IRWrite, PC_next); end
        total++; if (inst_sram_addr !== 32'hbfc00004) begin bad++; $display("FAIL first_addr got=%h exp=bfc00004", inst_sram_addr); end
        step();
        total++; if (IRWrite !== 1'b1 || PC_next !== 32'hbfc00004) begin bad++; $display("FAIL second_fetch got=%b/%h exp=1/bfc00004", IRWrite, PC_next); end
        total++; if (inst_sram_addr !== 32'hbfc00008) begin bad++; $display("FAIL second_addr got=%h exp=bfc00008", inst_sram_addr); end
        step(); step(); step();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (inst_sram_addr !== 32'hbfc00010 || IRWrite !== 1'b0 || PC_next !== 32'hbfc00010) begin
                bad++; $display("FAIL stall_hold[%0d] got=%h/%b/%h exp=bfc00010/0/bfc00010", i, inst_sram_addr, IRWrite, PC_next);
            end
            step();
        end
        stall = 1'b0;
        #1;
        total++; if (IRWrite !== 1'b1 || PC_next !== 32'hbfc00010 || inst_sram_addr !== 32'hbfc00014) begin
            bad++; $display("FAIL stall_resume got=%b/%h/%h exp=1/bfc00010/bfc00014", IRWrite, PC_next, inst_sram_addr);
        end
        step();
    endtask

    task automatic test_branch();
        step(); step(); step(); step();
        Is_branch_ID = 1'b1; Branch_taken_ID = 1'b1; Branch_target_ID = 32'hbfc00100;
        #1;
        total++; if (DSI_ID !== 1'b1 || PC_next !== 32'hbfc00024) begin bad++; $display("FAIL delay_slot got=%b/%h exp=1/bfc00024", DSI_ID, PC_next); end
        total++; if (IRWrite !== 1'b1 || inst_sram_addr !== 32'hbfc00100) begin bad++; $display("FAIL branch_addr got=%b/%h exp=1/bfc00100", IRWrite, inst_sram_addr); end
        step();
        idle_inputs();
        #1;
        total++; if (DSI_ID !== 1'b0 || PC_next !== 32'hbfc00100 || inst_sram_addr !== 32'hbfc00104) begin
            bad++; $display("FAIL branch_target got=%b/%h/%h exp=0/bfc00100/bfc00104", DSI_ID, PC_next, inst_sram_addr);
        end
    endtask

    task automatic test_misaligned();
        Is_branch_ID = 1'b1; Branch_taken_ID = 1'b1; Branch_target_ID = 32'hbfc00102;
        #1;
        total++; if (inst_sram_addr !== 32'hbfc00100) begin bad++; $display("FAIL misalign_addr got=%h exp=bfc00100", inst_sram_addr); end
        step();
        idle_inputs();
        #1;
        total++; if (PC_next !== 32'hbfc00102 || PC_AdEL !== 1'b1) begin bad++; $display("FAIL misalign_adel got=%h/%b exp=bfc00102/1", PC_next, PC_AdEL); end
        total++; if (inst_sram_addr !== 32'hbfc00104) begin bad++; $display("FAIL misalign_next got=%h exp=bfc00104", inst_sram_addr); end
    endtask

    task automatic test_exception();
        stall = 1'b1; exc_req = 1'b1; Is_branch_ID = 1'b1;
        #1;
        total++; if (IRWrite !== 1'b0 || inst_sram_addr !== 32'hbfc00380) begin bad++; $display("FAIL exc_stall got=%b/%h exp=0/bfc00380", IRWrite, inst_sram_addr); end
        total++; if (DSI_ID !== 1'b0) begin bad++; $display("FAIL exc_dsi got=%b exp=0", DSI_ID); end
        step();
        idle_inputs();
        #1;
        total++; if (PC_next !== 32'hbfc00380 || IRWrite !== 1'b1 || PC_AdEL !== 1'b0) begin
            bad++; $display("FAIL exc_vector got=%h/%b/%b exp=bfc00380/1/0", PC_next, IRWrite, PC_AdEL);
        end
        step();
    endtask

    task automatic test_eret();
        exc_req = 1'b1; eret_req = 1'b1; EPC = 32'hbfc00040;
        #1;
        total++; if (inst_sram_addr !== 32'hbfc00380 || IRWrite !== 1'b0) begin bad++; $display("FAIL exc_over_eret got=%h/%b exp=bfc00380/0", inst_sram_addr, IRWrite); end
        step();
        idle_inputs();
        eret_req = 1'b1; EPC = 32'hbfc00040;
        #1;
`ifdef PCGEN_ERET_EN
        total++; if (inst_sram_addr !== 32'hbfc00040 || IRWrite !== 1'b0) begin bad++; $display("FAIL eret_addr got=%h/%b exp=bfc00040/0", inst_sram_addr, IRWrite); end
        step();
        idle_inputs();
        #1;
        total++; if (PC_next !== 32'hbfc00040) begin bad++; $display("FAIL eret_pc got=%h exp=bfc00040", PC_next); end
`else
        total++; if (inst_sram_addr !== 32'hbfc00384 || IRWrite !== 1'b1) begin bad++; $display("FAIL eret_ignored got=%h/%b exp=bfc00384/1", inst_sram_addr, IRWrite); end
        step();
        idle_inputs();
        #1;
        total++; if (PC_next !== 32'hbfc00384) begin bad++; $display("FAIL eret_ignored_pc got=%h exp=bfc00384", PC_next); end
`endif
    endtask

    task automatic test_wrap();
        Branch_taken_ID = 1'b1; Branch_target_ID = 32'hfffffffc;
        step();
        idle_inputs();
        #1;
        total++; if (PC_next !== 32'hfffffffc || inst_sram_addr !== 32'h00000000) begin bad++; $display("FAIL wrap_addr got=%h/%h exp=fffffffc/00000000", PC_next, inst_sram_addr); end
        step();
        total++; if (PC_next !== 32'h00000000 || IRWrite !== 1'b1) begin bad++; $display("FAIL wrap_pc got=%h/%b exp=00000000/1", PC_next, IRWrite); end
    endtask

    task automatic test_async_reset();
        step(); step();
        #2;
        resetn = 1'b0;
        #1;
        total++; if (PC_next !== 32'hbfbffffc || IRWrite !== 1'b0) begin bad++; $display("FAIL async_rst got=%h/%b exp=bfbffffc/0", PC_next, IRWrite); end
        step();
        exc_req = 1'b1;
        resetn  = 1'b1;
        #1;
        total++; if (IRWrite !== 1'b0 || inst_sram_addr !== 32'hbfc00380 || DSI_ID !== 1'b0) begin
            bad++; $display("FAIL boot_redirect got=%b/%h/%b exp=0/bfc00380/0", IRWrite, inst_sram_addr, DSI_ID);
        end
        step();
        idle_inputs();
        #1;
        total++; if (PC_next !== 32'hbfc00380 || IRWrite !== 1'b1 || inst_sram_addr !== 32'hbfc00384) begin
            bad++; $display("FAIL boot_redirect_run got=%h/%b/%h exp=bfc00380/1/bfc00384", PC_next, IRWrite, inst_sram_addr);
        end
    endtask

    initial begin
        test_reset();
        test_boot_seq();
        test_stall();
        test_branch();
        test_misaligned();
        step();
        test_exception();
        test_eret();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

PC-generation unit for the 5-stage pipelined CPU. It owns the architectural fetch PC, drives the instruction SRAM address, and supplies the fetch stage with `PC_next`, `PC_AdEL`, `IRWrite` and the delay-slot tag `DSI_ID`. It sits between the hazard/branch/exception logic and the fetch stage, and is the producer side of the fetch stage's PC/IRWrite interface. The SRAM is synchronous with 1-cycle read latency, so `PC_next` is always the address issued on the previous cycle.

## Interface
- `RESET_VEC`, default 32'hbfc00000: first fetched address after reset.
- `EXC_VEC`, default 32'hbfc00380: exception entry address.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset; one clock domain.
- `stall`  in  1  hazard-unit stall; holds PC and IF/ID.
- `Is_branch_ID`  in  1  ID holds a branch/jump, so the instruction now being fetched is its delay slot.
- `Branch_taken_ID`  in  1  branch/jump in ID is taken.
- `Branch_target_ID`  in  32  taken target.
- `exc_req`  in  1  single-cycle exception redirect pulse.
- `eret_req`  in  1  single-cycle ERET redirect pulse.
- `EPC`  in  32  ERET return address.
- `inst_sram_addr`  out  32  SRAM read address, combinational, word-aligned.
- `PC_next`  out  32  address whose data is on `inst_sram_rdata` this cycle (= `pc_q`).
- `PC_AdEL`  out  1  `pc_q[1:0] != 0`.
- `IRWrite`  out  1  fetch stage latches PC and instruction at the next edge.
- `DSI_ID`  out  1  instruction being latched is a delay slot.

## Operation
- State: `pc_q` (32), FSM {BOOT, RUN}.
- Reset: `pc_q` = `RESET_VEC`-4 (32'hbfbffffc). FSM = BOOT. Outputs during reset: `PC_next` 32'hbfbffffc, `PC_AdEL` 0, `IRWrite` 0, `DSI_ID` 0, `inst_sram_addr` `RESET_VEC`.
- The next address `npc` is selected by priority; the first matching row applies:
  - `exc_req`: `npc` = `EXC_VEC`. `IRWrite` = 0. Any stall is overridden.
  - `eret_req`: `npc` = `EPC`. `IRWrite` = 0. Any stall is overridden.
  - BOOT: `npc` = `pc_q`+4 = `RESET_VEC`. `IRWrite` = 0. Next state is RUN.
  - RUN with `stall`: `npc` = `pc_q`, which re-reads the same word so `rdata` stays valid. `IRWrite` = 0.
  - RUN with `Branch_taken_ID`: `npc` = `Branch_target_ID`. `IRWrite` = 1.
  - RUN otherwise: `npc` = `pc_q`+4, with 32-bit wrap (32'hfffffffc → 0). `IRWrite` = 1.
- `pc_q` <= `npc` every cycle.
- `inst_sram_addr` = {`npc[31:2]`, 2'b00}. Misaligned targets are still issued aligned. `pc_q` keeps the raw bits, so `PC_AdEL` flags the fault when that PC reaches fetch.
- `DSI_ID` = `Is_branch_ID` & (FSM==RUN) & ~`exc_req` & ~`eret_req`.
- `Branch_taken_ID` is ignored while `stall` = 1. The hazard unit holds the branch in ID until the stall clears.
- `exc_req` and `eret_req` together: exception wins.
- Redirect in BOOT: the redirect wins and the FSM still moves to RUN.

## Timing
- Address issued in cycle N; data and `PC_next` valid in N+1; fetch stage latches at the end of N+1 when `IRWrite`=1.
- First `IRWrite`=1 is in the 2nd cycle after `resetn` rises, with `PC_next`=32'hbfc00000.
- Branch redirect: 0 bubbles beyond the delay slot. The target is fetched in the cycle after the delay slot is latched.
- Exception/ERET: exactly 1 `IRWrite`=0 cycle, then the vector instruction is available for latching.
- `resetn` asserted mid-operation: all state returns to reset values immediately (asynchronous). Release re-enters BOOT.

## Configuration
- `PCGEN_ERET_EN` defined: ERET redirect is supported as specified.
- `PCGEN_ERET_EN` undefined: `eret_req` and `EPC` are ignored and that priority row is removed. All other behaviour is identical.

## Test plan
- Reset release, no stall → `inst_sram_addr` 32'hbfc00000, 32'hbfc00004, …. First `IRWrite`=1 cycle has `PC_next`=32'hbfc00000; the next has 32'hbfc00004.
- `stall`=1 for 3 cycles at `pc_q`=32'hbfc00010 → `inst_sram_addr` held at 32'hbfc00010 and `IRWrite`=0 for 3 cycles. Then `IRWrite`=1 with `PC_next`=32'hbfc00010, and `inst_sram_addr` resumes at 32'hbfc00014.
- `Is_branch_ID`=1 and `Branch_taken_ID`=1, target 32'hbfc00100, at `pc_q`=32'hbfc00024 → `DSI_ID`=1 with `PC_next`=32'hbfc00024. Next `PC_next` is 32'hbfc00100 with `DSI_ID`=0.
- `exc_req` pulse while `stall`=1 → `IRWrite`=0, `inst_sram_addr`=32'hbfc00380. Next cycle `PC_next`=32'hbfc00380.
- Taken target 32'hbfc00102 → `inst_sram_addr`=32'hbfc00100. Next cycle `PC_next`=32'hbfc00102 and `PC_AdEL`=1.
- `eret_req` with `EPC`=32'hbfc00040 and `exc_req` in the same cycle → `inst_sram_addr`=32'hbfc00380. With `PCGEN_ERET_EN` undefined, `eret_req` alone → sequential `pc_q`+4.
